// File: rtl/text_ram_arbiter.sv
// Shares one single-port synchronous text RAM between a video fetcher (strict priority,
// fixed 1-cycle read latency) and a host port buffered through a one-entry request slot.
module text_ram_arbiter #(
  parameter int unsigned D       = 10,
  parameter int unsigned W       = 8,
  parameter int unsigned MAXWAIT = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         vid_req,
  input  logic [D-1:0] vid_addr,
  output logic [W-1:0] vid_data,
  output logic         vid_valid,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic         host_we,
  input  logic [D-1:0] host_addr,
  input  logic [W-1:0] host_wdata,
  output logic [W-1:0] host_rdata,
  output logic         host_rvalid,
  output logic         host_wdone,
  output logic         host_starved,
  input  logic         starve_clr,
  output logic [D-1:0] ram_addr,
  output logic [W-1:0] ram_din,
  output logic         ram_we,
  input  logic [W-1:0] ram_dout
);

  localparam int unsigned CW = 16;

  typedef enum logic {EMPTY, PENDING} buf_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_HOSTRD, OWN_HOSTWR} owner_t;

  buf_state_t     state, state_nxt;
  owner_t         owner, owner_nxt;
  logic           buf_we;
  logic [D-1:0]   buf_addr;
  logic [W-1:0]   buf_wdata;
  logic [D-1:0]   addr_hold;
  logic [W-1:0]   din_hold;
  logic [CW-1:0]  wait_cnt, wait_cnt_nxt;
  logic           starved_q, starved_nxt;
  logic           accept_c, issue_c, starve_set_c;

  // Grant, buffer next-state, wait counter and starvation flag
  always_comb begin
    state_nxt    = state;
    owner_nxt    = OWN_NONE;
    ram_addr     = addr_hold;
    ram_din      = din_hold;
    ram_we       = 1'b0;
    accept_c     = (state == EMPTY) && host_valid;
    issue_c      = 1'b0;
    wait_cnt_nxt = wait_cnt;
    starve_set_c = 1'b0;
    starved_nxt  = starved_q;

    if (vid_req) begin
      ram_addr  = vid_addr;
      owner_nxt = OWN_VID;
    end else if (state == PENDING) begin
      ram_addr  = buf_addr;
      ram_din   = buf_wdata;
      ram_we    = buf_we;
      issue_c   = 1'b1;
      owner_nxt = buf_we ? OWN_HOSTWR : OWN_HOSTRD;
    end

    case (state)
      EMPTY: begin
        wait_cnt_nxt = '0;
        if (accept_c) state_nxt = PENDING;
      end
      PENDING: begin
        if (issue_c) begin
          state_nxt    = EMPTY;
          wait_cnt_nxt = '0;
        end else begin
          if (wait_cnt < CW'(MAXWAIT)) wait_cnt_nxt = wait_cnt + CW'(1);
          // Losing this cycle makes the count reach MAXWAIT (or it is already there)
          starve_set_c = (wait_cnt >= CW'(MAXWAIT - 1));
        end
      end
      default: state_nxt = EMPTY;
    endcase

    if (starve_set_c)    starved_nxt = 1'b1;
    else if (starve_clr) starved_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      owner     <= OWN_NONE;
      wait_cnt  <= '0;
      starved_q <= 1'b0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      wait_cnt  <= wait_cnt_nxt;
      starved_q <= starved_nxt;
      addr_hold <= ram_addr;
      din_hold  <= ram_din;
    end
  end

  // One-entry host request buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (accept_c) begin
      buf_we    <= host_we;
      buf_addr  <= host_addr;
      buf_wdata <= host_wdata;
    end
  end

  assign host_ready   = (state == EMPTY);
  assign vid_valid    = (owner == OWN_VID);
  assign host_rvalid  = (owner == OWN_HOSTRD);
  assign host_wdone   = (owner == OWN_HOSTWR);
  assign host_starved = starved_q;
  assign vid_data     = ram_dout;
  assign host_rdata   = ram_dout;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: external RAM, golden-memory transaction model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_text_ram_arbiter;

  localparam int unsigned D = 10;
  localparam int unsigned W = 8;
  localparam int unsigned MAXWAIT = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         vid_req = 1'b0;
  logic [D-1:0] vid_addr = '0;
  logic [W-1:0] vid_data;
  logic         vid_valid;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic         host_we = 1'b0;
  logic [D-1:0] host_addr = '0;
  logic [W-1:0] host_wdata = '0;
  logic [W-1:0] host_rdata;
  logic         host_rvalid;
  logic         host_wdone;
  logic         host_starved;
  logic         starve_clr = 1'b0;
  logic [D-1:0] ram_addr;
  logic [W-1:0] ram_din;
  logic         ram_we;
  logic [W-1:0] ram_dout;

  int vectors = 0;
  int errors  = 0;

  text_ram_arbiter #(.D(D), .W(W), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_wdone(host_wdone), .host_starved(host_starved),
    .starve_clr(starve_clr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int i);
    return W'(i * 37 + 11);
  endfunction

  // Single-port RAM: registered read returns old data on a write cycle
  logic [W-1:0] tb_mem [0:(1<<D)-1];
  always @(posedge clk) begin
    ram_dout <= tb_mem[ram_addr];
    if (ram_we) tb_mem[ram_addr] = ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: golden memory, request slot, lost-cycle count
  logic [W-1:0] gold [0:(1<<D)-1];
  bit           m_pend, m_we, m_vv, m_rv, m_wd, m_starved, m_issue;
  logic [D-1:0] m_addr;
  logic [W-1:0] m_wdata, m_vd, m_rd;
  int           m_lost;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend <= 0; m_vv <= 0; m_rv <= 0; m_wd <= 0; m_starved <= 0; m_lost <= 0;
    end else begin
      m_issue = m_pend && !vid_req;
      m_vv <= vid_req;
      m_vd <= gold[vid_addr];
      m_rv <= m_issue && !m_we;
      m_wd <= m_issue && m_we;
      m_rd <= gold[m_addr];
      if (m_issue && m_we) gold[m_addr] = m_wdata;
      if (!m_pend) begin
        m_lost <= 0;
        if (host_valid) begin
          m_pend <= 1; m_we <= host_we; m_addr <= host_addr; m_wdata <= host_wdata;
        end
      end else if (m_issue) begin
        m_pend <= 0; m_lost <= 0;
      end else begin
        m_lost <= (m_lost + 1 > int'(MAXWAIT)) ? int'(MAXWAIT) : m_lost + 1;
      end
      if (m_pend && vid_req && m_lost + 1 >= int'(MAXWAIT)) m_starved <= 1;
      else if (starve_clr) m_starved <= 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ready",   32'(host_ready),   32'd1);
      chk("rst_vvalid",  32'(vid_valid),    32'd0);
      chk("rst_rvalid",  32'(host_rvalid),  32'd0);
      chk("rst_wdone",   32'(host_wdone),   32'd0);
      chk("rst_starved", 32'(host_starved), 32'd0);
      chk("rst_ram_we",  32'(ram_we),       32'd0);
    end else begin
      chk("host_ready",   32'(host_ready),   32'(!m_pend));
      chk("vid_valid",    32'(vid_valid),    32'(m_vv));
      if (m_vv) chk("vid_data", 32'(vid_data), 32'(m_vd));
      chk("host_rvalid",  32'(host_rvalid),  32'(m_rv));
      if (m_rv) chk("host_rdata", 32'(host_rdata), 32'(m_rd));
      chk("host_wdone",   32'(host_wdone),   32'(m_wd));
      chk("host_starved", 32'(host_starved), 32'(m_starved));
      chk("ram_we",       32'(ram_we),       32'(m_pend && !vid_req && m_we));
      if (vid_req) chk("ram_addr_vid", 32'(ram_addr), 32'(vid_addr));
      else if (m_pend) begin
        chk("ram_addr_host", 32'(ram_addr), 32'(m_addr));
        if (m_we) chk("ram_din", 32'(ram_din), 32'(m_wdata));
      end
    end
  end

  // Uncontended host access; lat counts edges from acceptance to the completion pulse
  task automatic host_op(input bit we, input int addr, input int wd,
                         output logic [W-1:0] rd, output int lat);
    @(posedge clk); #1;
    host_valid = 1'b1; host_we = we; host_addr = D'(addr); host_wdata = W'(wd);
    @(posedge clk); #1;
    host_valid = 1'b0;
    lat = 1;
    while (!(we ? host_wdone : host_rvalid) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = host_rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rd;
    int lat;
    for (int i = 0; i < (1 << D); i++) begin
      tb_mem[i] = pat(i);
      gold[i]   = pat(i);
    end

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din",  32'(ram_din),  32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Uncontended write 0x05 <- 0xA5, then read back
    host_op(1'b1, 'h05, 'hA5, rd, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    host_op(1'b0, 'h05, 0, rd, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_after_wr", 32'(rd), 32'hA5);

    // Video stream addr 0..15 back-to-back
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i >= 1) chk("vid_stream_valid", 32'(vid_valid), 32'd1);
      if (i == 4) chk("vid_addr3", 32'(vid_data), 32'h7A);
      if (i == 6) chk("vid_addr5", 32'(vid_data), 32'hA5);
      vid_req = (i < 16); vid_addr = D'(i);
    end
    @(posedge clk); #1;
    chk("vid_stream_end", 32'(vid_valid), 32'd0);

    // Contention: host read 0x3FF accepted while video busy for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i >= 1) chk("cont_ready", 32'(host_ready), 32'd0);
      vid_req = 1'b1; vid_addr = D'(32'h100 + i);
      host_valid = (i == 0); host_we = 1'b0; host_addr = D'(32'h3FF);
    end
    @(posedge clk); #1;
    chk("cont_ready_last", 32'(host_ready), 32'd0);
    chk("cont_no_rvalid", 32'(host_rvalid), 32'd0);
    vid_req = 1'b0;
    @(posedge clk); #1;
    chk("cont_rvalid", 32'(host_rvalid), 32'd1);
    chk("cont_rdata", 32'(host_rdata), 32'hE6);

    // Clear the flag left by the long contention
    starve_clr = 1'b1;
    @(posedge clk); #1;
    starve_clr = 1'b0;
    chk("clr_before_starve", 32'(host_starved), 32'd0);

    // Starvation: request pending, then 6 lost cycles
    for (int i = 0; i <= 6; i++) begin
      if (i == 4) chk("starve_after3", 32'(host_starved), 32'd0);
      if (i == 5) chk("starve_after4", 32'(host_starved), 32'd1);
      vid_req = 1'b1; vid_addr = D'(i);
      host_valid = (i == 0); host_we = 1'b0; host_addr = D'(32'h20);
      @(posedge clk); #1;
    end
    vid_req = 1'b0;
    @(posedge clk); #1;
    chk("starve_issue_rvalid", 32'(host_rvalid), 32'd1);
    chk("starve_rdata", 32'(host_rdata), 32'hAB);
    chk("starve_sticky", 32'(host_starved), 32'd1);
    starve_clr = 1'b1;
    @(posedge clk); #1;
    starve_clr = 1'b0;
    chk("starve_cleared", 32'(host_starved), 32'd0);

    // Reset while a write to 0x10 is pending
    vid_req = 1'b1; vid_addr = D'(1);
    host_valid = 1'b1; host_we = 1'b1; host_addr = D'(32'h10); host_wdata = W'(32'h77);
    @(posedge clk); #1;
    host_valid = 1'b0;
    chk("midrst_pending", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0; vid_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_wdone", 32'(host_wdone), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_wdone_after", 32'(host_wdone), 32'd0);
    host_op(1'b0, 'h10, 0, rd, lat);
    chk("midrst_ram_unchanged", 32'(rd), 32'h5B);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
Shares one single-port synchronous text RAM (1-cycle registered read, write-first-free: read returns old data on a write cycle) between the video character fetcher and a host (CPU/UART loader) port. Video has strict priority and a fixed 1-cycle read latency so scanout timing never slips. Host accesses go through a one-entry request buffer with a valid/ready handshake and are issued in cycles the video port leaves free. A wait counter flags host starvation.

Parameters:
D, 10, RAM address width (depth 2^D words)
W, 8, RAM data width
MAXWAIT, 64, host wait cycles before host_starved is set (1..2^16-1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
vid_req  in  1  video read request this cycle
vid_addr  in  D  video read address
vid_data  out  W  video read data
vid_valid  out  1  vid_data valid (one cycle after vid_req)
host_valid  in  1  host request offered
host_ready  out  1  buffer can accept request
host_we  in  1  1=write, 0=read
host_addr  in  D  host address
host_wdata  in  W  host write data
host_rdata  out  W  host read data
host_rvalid  out  1  host_rdata valid, one-cycle pulse
host_wdone  out  1  host write committed, one-cycle pulse
host_starved  out  1  sticky: a request waited >= MAXWAIT cycles
starve_clr  in  1  clears host_starved
ram_addr  out  D  to RAM addr
ram_din  out  W  to RAM din
ram_we  out  1  to RAM we
ram_dout  in  W  from RAM dout (registered inside RAM)

Behaviour:
- Reset (async, reset_n=0): buffer empty, host_ready=1, vid_valid=0, host_rvalid=0, host_wdone=0, host_starved=0, wait counter=0, owner register=NONE; ram_we=0, ram_addr=0, ram_din=0.
- Buffer states: EMPTY, PENDING. EMPTY->PENDING on host_valid&&host_ready (captures we/addr/wdata). PENDING->EMPTY in the cycle the buffered request is issued. No bypass: host_ready = (state==EMPTY); earliest issue is the cycle after acceptance.
- Grant (combinational, per cycle): vid_req=1 -> video owns RAM: ram_addr=vid_addr, ram_we=0. Else if PENDING -> host issued: ram_addr=buf_addr, ram_din=buf_wdata, ram_we=buf_we. Else idle: ram_we=0, ram_addr holds last value.
- Owner register (registered): VID, HOSTRD, HOSTWR or NONE for the grant of the previous cycle.
- Cycle after grant: owner VID -> vid_valid=1, vid_data=ram_dout. Owner HOSTRD -> host_rvalid=1, host_rdata=ram_dout. Owner HOSTWR -> host_wdone=1. vid_data/host_rdata are pass-through of ram_dout and are don't-care when the valid is low.
- Latency: video read 1 cycle, always. Host read, uncontended: accept t, issue t+1, host_rvalid t+2. Host write: host_wdone t+2, RAM updated at edge ending t+1.
- Wait counter: 0 while EMPTY; increments each PENDING cycle lost to video; saturates at MAXWAIT; reloads 0 on issue. Reaching MAXWAIT sets host_starved. starve_clr clears it unless the set condition occurs in the same cycle (set wins).
- Simultaneous: vid_req and PENDING in the same cycle -> video wins, host stays PENDING. host_valid is ignored while PENDING (host must hold it; ready=0). A new request can be accepted in the cycle after issue.
- Read-after-write: a host read issued after a completed write to the same address returns the new data.
- Reset mid-operation: a pending request is dropped silently; no rvalid or wdone is generated for it; RAM contents are unchanged by the controller.

Test Plan:
- Reset then idle: reset_n low 3 cycles -> host_ready=1, all valids 0, ram_we=0, host_starved=0.
- Uncontended host write addr 0x05 data 0xA5 then read 0x05 -> ram_we high 1 cycle, host_wdone at t+2; read host_rvalid at t+2 with host_rdata=0xA5.
- Video stream vid_req=1 for addr 0..15 back-to-back -> vid_valid continuous from the 2nd cycle, each vid_data equal to RAM[addr] of the previous cycle, no gaps.
- Contention: host read 0x3FF accepted while vid_req high 10 cycles -> host issued on the first cycle vid_req=0, host_rvalid 1 cycle later; video data unaffected; host_ready=0 throughout.
- Starvation (MAXWAIT=4): host pending, vid_req high 6 cycles -> host_starved set after 4 lost cycles and stays set after issue; starve_clr pulse -> 0.
- Reset asserted while PENDING with a write to 0x10 data 0x77 -> no host_wdone; RAM[0x10] unchanged on a later read.
